uart_step_bridge: RTL and testbench

//  Debug front-end between the uart byte interface and the control/ALU pair.
//  - Assembles RX bytes into a little-endian 32-bit instruction word.
//  - Issues exactly one single-step clock pulse per completed word.
//  - Returns the 16-bit result over TX, low byte first.
//  - Replaces the ad-hoc byte-collect/step/echo sequencer in the top level.

---
 rtl/uart_step_bridge_pkg.sv | 15 +
 rtl/uart_step_bridge_tx_seq.sv | 52 +++++
 rtl/uart_step_bridge.sv | 119 +++++++++++
 tb/tb_uart_step_bridge.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_step_bridge_pkg.sv
// uart_step_bridge_pkg: state encoding and frame constants shared by the UART step bridge.
// Frame length depends on UART_STEP_CHECKSUM_EN.
package uart_step_bridge_pkg;
    typedef enum logic [2:0] {RECV, STEP_LO, STEP_HI, TX0, TX1, WAIT_HI, WAIT_LO, NAK} state_t;
    localparam logic [7:0] NAK_BYTE = 8'hEE;
    localparam int WORD_BYTES = 4;
`ifdef UART_STEP_CHECKSUM_EN
    localparam int FRAME_BYTES = WORD_BYTES + 1;
    function automatic logic [7:0] xor_bytes(input logic [31:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction
`else
    localparam int FRAME_BYTES = WORD_BYTES;
`endif
endpackage

// File: rtl/uart_step_bridge_tx_seq.sv
// uart_tx_seq: sends one byte per request, gated on tx_busy, then tracks busy high/low.
// Idles in TX0; done pulses combinationally when the transmitter goes idle again.
module uart_tx_seq
    import uart_step_bridge_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       req,
    input  logic [7:0] byte_in,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       done
);
    state_t     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       start_q, start_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        start_d = 1'b0;
        done    = 1'b0;
        case (state_q)
            WAIT_HI: if (tx_busy) state_d = WAIT_LO;
            WAIT_LO: if (!tx_busy) begin
                state_d = TX0;
                done    = 1'b1;
            end
            default: if (req && !tx_busy) begin
                state_d = WAIT_HI;
                data_d  = byte_in;
                start_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= TX0;
            data_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            start_q <= start_d;
        end
    end

    assign tx_data  = data_q;
    assign tx_start = start_q;
endmodule

// File: rtl/uart_step_bridge.sv
// uart_step_bridge: collects RX bytes into a 32-bit word, single-steps control, returns result over TX.
// UART_STEP_CHECKSUM_EN adds a 5th XOR checksum byte with a NAK reply on mismatch.
module uart_step_bridge
    import uart_step_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 50000,
    parameter int STEP_LOW_CYCLES = 1,
    parameter int SETTLE_CYCLES   = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic [31:0] word,
    output logic        step_clk,
    input  logic [15:0] result,
    output logic        err
);
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   word_q, word_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   res_q, res_d;
    logic          step_q, step_d;
    logic          done;

    uart_tx_seq u_tx (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .req     (state_q == TX0 || state_q == TX1 || state_q == NAK),
        .byte_in (state_q == NAK ? NAK_BYTE : (state_q == TX1 ? res_q[15:8] : res_q[7:0])),
        .tx_busy (tx_busy),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .done    (done)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err     = 1'b0;
        case (state_q)
            RECV: if (rx_ready) begin
                gap_d = '0;
                idx_d = idx_q + 3'd1;
                if (idx_q < 3'(WORD_BYTES)) word_d[{idx_q[1:0], 3'b000} +: 8] = rx_data;
                if (idx_q == 3'(FRAME_BYTES - 1)) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = STEP_LO;
`ifdef UART_STEP_CHECKSUM_EN
                    if (rx_data != xor_bytes(word_q)) begin
                        state_d = NAK;
                        err     = 1'b1;
                    end
`endif
                end
            end else if (idx_q != '0) begin
                // a byte arriving on the timeout cycle takes the branch above instead
                if (gap_q == GW'(TIMEOUT_CYCLES - 1)) begin
                    err   = 1'b1;
                    idx_d = '0;
                    gap_d = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            STEP_LO: if (cnt_q == 16'(STEP_LOW_CYCLES - 1)) begin
                state_d = STEP_HI;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            STEP_HI: if (cnt_q == 16'(SETTLE_CYCLES - 1)) begin
                state_d = TX0;
                res_d   = result;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            TX0: if (done) state_d = TX1;
            default: if (done) state_d = RECV;
        endcase
        if (rx_ready && state_q != RECV) err = 1'b1;
        step_d = (state_d != STEP_LO);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= RECV;
            idx_q   <= '0;
            word_q  <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            step_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            step_q  <= step_d;
        end
    end

    assign word     = word_q;
    assign step_clk = step_q;
endmodule

// File: tb/tb_uart_step_bridge.sv
// tb_uart_step_bridge: directed table-driven bench with a simple UART transmitter model.
module tb_uart_step_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready = 1'b0;
    logic        hold_busy = 1'b0;
    logic [15:0] result = '0;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [31:0] word;
    logic        step_clk;
    logic        err;

    int busy_cnt = 0;
    int steps = 0, lowc = 0, errs = 0, starts = 0;
    int tests = 0, fails = 0;
    logic [7:0] txq[$];

    typedef struct {
        logic [3:0][7:0] b;
        logic [15:0]     res;
        logic [31:0]     exp_word;
        logic [7:0]      exp_lo;
        logic [7:0]      exp_hi;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;
    assign tx_busy = hold_busy || (busy_cnt != 0);

    uart_step_bridge #(.TIMEOUT_CYCLES(40), .STEP_LOW_CYCLES(2), .SETTLE_CYCLES(3)) dut (
        .CLK(clk), .RST_N(rst_n), .rx_data(rx_data), .rx_ready(rx_ready), .tx_busy(tx_busy),
        .tx_data(tx_data), .tx_start(tx_start), .word(word), .step_clk(step_clk),
        .result(result), .err(err)
    );

    always @(posedge clk) begin
        if (tx_start) begin
            txq.push_back(tx_data);
            busy_cnt <= 4;
            starts <= starts + 1;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (rst_n && !step_clk) lowc <= lowc + 1;
        if (err) errs <= errs + 1;
    end

    always @(negedge step_clk) if (rst_n) steps <= steps + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0][7:0] b);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) tick(2);
            send_byte(b[i]);
        end
`ifdef UART_STEP_CHECKSUM_EN
        tick(2);
        send_byte(b[0] ^ b[1] ^ b[2] ^ b[3]);
`endif
    endtask

    task automatic wait_tx(input int n);
        int t = 0;
        while ((txq.size() < n || tx_busy) && t < 300) begin
            tick(1);
            t++;
        end
        chk("tx_wait_bound", 32'(t < 300), 1);
        tick(3);
    endtask

    task automatic run_frame(input string tag, input vec_t v);
        int s0 = steps, l0 = lowc, e0 = errs, lat = 1;
        result = v.res;
        txq.delete();
        send_frame(v.b);
        chk({tag, "_step_fall"}, 32'(step_clk), 0);
        while (!tx_start && lat < 50) begin
            tick(1);
            lat++;
        end
        chk({tag, "_tx_latency"}, lat, 7);
        wait_tx(2);
        chk({tag, "_word"}, word, v.exp_word);
        chk({tag, "_steps"}, steps - s0, 1);
        chk({tag, "_low_width"}, lowc - l0, 2);
        chk({tag, "_err"}, errs - e0, 0);
        chk({tag, "_tx_count"}, txq.size(), 2);
        if (txq.size() >= 2) begin
            chk({tag, "_tx_lo"}, txq[0], v.exp_lo);
            chk({tag, "_tx_hi"}, txq[1], v.exp_hi);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0, e0, st0, t;
        vec_t rv;
        vecs[0] = '{b: {8'h12, 8'h34, 8'h56, 8'h78}, res: 16'hBEEF, exp_word: 32'h12345678, exp_lo: 8'hEF, exp_hi: 8'hBE};
        vecs[1] = '{b: {8'hFF, 8'h00, 8'hA5, 8'h5A}, res: 16'h0001, exp_word: 32'hFF00A55A, exp_lo: 8'h01, exp_hi: 8'h00};
        vecs[2] = '{b: {8'h80, 8'h40, 8'h20, 8'h10}, res: 16'h8000, exp_word: 32'h80402010, exp_lo: 8'h00, exp_hi: 8'h80};
        vecs[3] = '{b: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, res: 16'hFFFF, exp_word: 32'hFFFFFFFF, exp_lo: 8'hFF, exp_hi: 8'hFF};
        rv = '{b: {8'h04, 8'h03, 8'h02, 8'h01}, res: 16'h5AA5, exp_word: 32'h04030201, exp_lo: 8'hA5, exp_hi: 8'h5A};

        tick(3);
        chk("rst_step_clk", 32'(step_clk), 1);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_word", word, 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        tick(1);

        send_frame(rv.b);
        tick(1);
        chk("pre_rst_step_low", 32'(step_clk), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_step_clk", 32'(step_clk), 1);
        chk("async_rst_tx_start", 32'(tx_start), 0);
        chk("async_rst_word", word, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        run_frame("post_rst", rv);

        for (int i = 0; i < 4; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

        e0 = errs;
        s0 = steps;
        send_byte(8'hAA);
        tick(2);
        send_byte(8'hBB);
        tick(39);
        chk("timeout_not_early", errs - e0, 0);
        tick(1);
        chk("timeout_err", errs - e0, 1);
        tick(20);
        chk("timeout_single_err", errs - e0, 1);
        chk("timeout_no_step", steps - s0, 0);
        rv = '{b: {8'h0D, 8'h0C, 8'h0B, 8'h0A}, res: 16'h1357, exp_word: 32'h0D0C0B0A, exp_lo: 8'h57, exp_hi: 8'h13};
        run_frame("after_timeout", rv);

        e0 = errs;
        s0 = steps;
        txq.delete();
        send_byte(8'h11);
        tick(39);
        send_byte(8'h22);
        chk("timeout_tie_no_err", errs - e0, 0);
        tick(2);
        send_byte(8'h33);
        tick(2);
        send_byte(8'h44);
`ifdef UART_STEP_CHECKSUM_EN
        tick(2);
        send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
`endif
        wait_tx(2);
        chk("timeout_tie_word", word, 32'h44332211);
        chk("timeout_tie_step", steps - s0, 1);

        result = 16'h1234;
        txq.delete();
        e0 = errs;
        send_frame({8'hDD, 8'hCC, 8'hBB, 8'hAA});
        t = 0;
        while (txq.size() < 1 && t < 100) begin
            tick(1);
            t++;
        end
        chk("overrun_first_tx_bound", 32'(t < 100), 1);
        tick(1);
        send_byte(8'h99);
        chk("overrun_err", errs - e0, 1);
        wait_tx(2);
        chk("overrun_tx_count", txq.size(), 2);
        if (txq.size() >= 2) begin
            chk("overrun_tx_lo", txq[0], 8'h34);
            chk("overrun_tx_hi", txq[1], 8'h12);
        end
        chk("overrun_word_kept", word, 32'hDDCCBBAA);
        run_frame("after_overrun", vecs[0]);

        hold_busy = 1'b1;
        result = 16'hCAFE;
        txq.delete();
        st0 = starts;
        s0 = steps;
        send_frame({8'h87, 8'h65, 8'h43, 8'h21});
        tick(100);
        chk("busy_hold_no_start", starts - st0, 0);
        chk("busy_hold_stepped", steps - s0, 1);
        hold_busy = 1'b0;
        wait_tx(2);
        chk("busy_release_starts", starts - st0, 2);
        if (txq.size() >= 2) begin
            chk("busy_release_lo", txq[0], 8'hFE);
            chk("busy_release_hi", txq[1], 8'hCA);
        end

`ifdef UART_STEP_CHECKSUM_EN
        result = 16'h00C3;
        txq.delete();
        s0 = steps;
        e0 = errs;
        send_byte(8'h01); tick(2); send_byte(8'h02); tick(2);
        send_byte(8'h03); tick(2); send_byte(8'h04); tick(2); send_byte(8'h04);
        wait_tx(2);
        chk("cs_ok_step", steps - s0, 1);
        chk("cs_ok_err", errs - e0, 0);
        chk("cs_ok_word", word, 32'h04030201);
        txq.delete();
        s0 = steps;
        e0 = errs;
        send_byte(8'h01); tick(2); send_byte(8'h02); tick(2);
        send_byte(8'h03); tick(2); send_byte(8'h04); tick(2); send_byte(8'h00);
        wait_tx(1);
        tick(10);
        chk("cs_bad_no_step", steps - s0, 0);
        chk("cs_bad_err", errs - e0, 1);
        chk("cs_bad_tx_count", txq.size(), 1);
        if (txq.size() >= 1) chk("cs_bad_nak", txq[0], 8'hEE);
        chk("cs_bad_word", word, 32'h04030201);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
